// File: rtl/rf_staged_32x32.sv
// 32x32 register file with a one-entry write staging register, decoded one-hot
// commit enables, and two registered read ports that bypass the staged write.
module rf_staged_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  R_VALID
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  stg_valid_reg;
    logic [ADDR_WIDTH-1:0] stg_addr_reg;
    logic [DATA_WIDTH-1:0] stg_data_reg;

    logic [NUM_REGS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_next [2];
    logic [DATA_WIDTH-1:0] rd_data_reg [2];
    logic                  r_valid_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stg_valid_reg <= 1'b0;
            stg_addr_reg  <= '0;
            stg_data_reg  <= '0;
        end else begin
            stg_valid_reg <= WRITE;
            if (WRITE) begin
                stg_addr_reg <= ADDR_W;
                stg_data_reg <= DATA_W;
            end
        end
    end

    // One-hot commit decode of the staged address; entry 0 never commits.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr_en[gi] = 1'b0;
            end else begin : g_dec
                assign wr_en[gi] = stg_valid_reg && (stg_addr_reg == ADDR_WIDTH'(gi));
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en[gi]) begin
                    regs_reg[gi] <= stg_data_reg;
                end
            end
        end
    endgenerate

    assign rd_addr[0] = ADDR_R1;
    assign rd_addr[1] = ADDR_R2;

    // Read select priority: address 0, then the staged write, then the array.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_comb begin
                rd_next[gi] = regs_reg[rd_addr[gi]];
                if (stg_valid_reg && (stg_addr_reg == rd_addr[gi])) begin
                    rd_next[gi] = stg_data_reg;
                end
                if (rd_addr[gi] == '0) begin
                    rd_next[gi] = '0;
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    rd_data_reg[gi] <= '0;
                end else if (READ) begin
                    rd_data_reg[gi] <= rd_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid_reg <= 1'b0;
        end else begin
            r_valid_reg <= READ;
        end
    end

    assign DATA_R1 = rd_data_reg[0];
    assign DATA_R2 = rd_data_reg[1];
    assign R_VALID = r_valid_reg;
endmodule

// File: tb/tb_rf_staged_32x32.sv
// Directed bench for rf_staged_32x32: vector table plus hand-written reset,
// decode-sweep and reset-during-write sequences.
module tb_rf_staged_32x32;
    logic        CLK;
    logic        RESET;
    logic        WRITE;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        READ;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        R_VALID;

    int errors = 0;
    int checks = 0;

    rf_staged_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
        .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .R_VALID(R_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic        rd;
        logic [4:0]  ar1;
        logic [4:0]  ar2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        expv;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check3(input string name, input logic [31:0] e1, input logic [31:0] e2,
                          input logic ev);
        check({name, " R1"}, DATA_R1, e1);
        check({name, " R2"}, DATA_R2, e2);
        check({name, " RV"}, {31'd0, R_VALID}, {31'd0, ev});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                         input logic rd, input logic [4:0] a1, input logic [4:0] a2);
        WRITE = wr; ADDR_W = aw; DATA_W = dw;
        READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
    endtask

    initial begin
        // wr aw dw rd ar1 ar2 exp1 exp2 expv  (outputs after the edge)
        tbl[0]  = '{1'b1, 5'd5, 32'hAAAA_AAAA, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1};
        tbl[4]  = '{1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 5'd0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
        tbl[6]  = '{1'b1, 5'd7, 32'h5555_5555, 1'b1, 5'd7, 5'd5, 32'h1111_1111, 32'hAAAA_AAAA, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd7, 32'h5555_5555, 32'h5555_5555, 1'b1};
        tbl[8]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd7, 5'd0, 32'h5555_5555, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 5'd3, 32'h0000_1234, 1'b1, 5'd3, 5'd3, 32'h0, 32'h0, 1'b1};
        tbl[12] = '{1'b1, 5'd3, 32'h0000_5678, 1'b1, 5'd3, 5'd3, 32'h0000_1234, 32'h0000_1234, 1'b1};
        tbl[13] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd5, 32'h0000_5678, 32'hAAAA_AAAA, 1'b1};
        tbl[14] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 32'h0000_5678, 32'h0000_5678, 1'b1};

        RESET = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        #3 RESET = 1'b1;
        #1 check3("reset async", 32'h0, 32'h0, 1'b0);
        step();
        step();
        RESET = 1'b0;

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
            step();
            check3($sformatf("post-reset read %0d/%0d", i, 31 - i), 32'h0, 32'h0, 1'b1);
        end

        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].wr, tbl[v].aw, tbl[v].dw, tbl[v].rd, tbl[v].ar1, tbl[v].ar2);
            step();
            check3($sformatf("vec %0d", v), tbl[v].exp1, tbl[v].exp2, tbl[v].expv);
        end

        // Decode sweep: distinct value into r1..r31, then read mirrored pairs.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0);
            step();
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(32 - i));
            step();
            check3($sformatf("sweep %0d/%0d", i, 32 - i),
                   32'h100 + 32'(i), 32'h100 + 32'(32 - i), 1'b1);
        end

        // Mid-cycle reset while a read result is valid.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd10);
        step();
        check3("pre mid-reset", 32'h109, 32'h10A, 1'b1);
        #2 RESET = 1'b1;
        #1 check3("mid-cycle reset", 32'h0, 32'h0, 1'b0);
        #1 RESET = 1'b0;
        step();
        check3("read after reset", 32'h0, 32'h0, 1'b1);

        // Staged write killed by reset before it can commit.
        drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        step();
        #2 RESET = 1'b1;
        #1 RESET = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        step();
        check3("r9 after reset mid-write", 32'h0, 32'h0, 1'b1);
        step();
        check3("r9 again", 32'h0, 32'h0, 1'b1);

        drive(1'b1, 5'd4, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd9);
        step();
        check3("r4 bypass", 32'hCAFE_F00D, 32'h0, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        step();
        check3("hold READ=0", 32'hCAFE_F00D, 32'h0, 1'b0);
        step();
        check3("hold READ=0 again", 32'hCAFE_F00D, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
